// File: rtl/pht_port_scheduler_pkg.sv
// Shared types and helpers for the PHT port scheduler: branch outcomes,
// scheduler states, buffered update entries and counter arithmetic.
package pht_port_scheduler_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int PHT_INDEX_MAX = 16;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    READ,
    WRITE
  } PhtState;

  // Index is stored at the widest supported size; users keep the low bits.
  typedef struct packed {
    logic [PHT_INDEX_MAX-1:0] index;
    BranchOutcome             outcome;
  } PhtUpdate;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input BranchOutcome outcome);
    if (outcome == TAKEN) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/pht_port_scheduler_fifo.sv
// Circular buffer of pending PHT updates; a push into a full buffer is
// accepted only when a pop frees the head slot in the same cycle.
module pht_update_fifo
  import pht_port_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  PhtUpdate push_data,
  input  logic     pop,
  output PhtUpdate head,
  output logic     full,
  output logic     empty,
  output logic     one_left
);

  localparam int AW = $clog2(DEPTH);

  PhtUpdate      mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          accept, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign one_left = ((wr_ptr - rd_ptr) == (AW+1)'(1));
  assign do_pop   = pop && !empty;
  assign accept   = push && (!full || do_pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pht_port_scheduler.sv
// Arbitrates the single PHT port between same-cycle decode lookups and
// buffered read-modify-write counter updates, after a full-table init.
module pht_port_scheduler
  import pht_port_scheduler_pkg::*;
#(
  parameter int INDEX_WIDTH  = 7,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_pc,
  output BranchOutcome           o_req_prediction,
  output logic                   o_stall_req,
  input  logic                   i_fb_valid,
  input  logic [ADDR_WIDTH-1:0]  i_fb_pc,
  input  BranchOutcome           i_fb_outcome,
  output logic                   o_fb_drop,
  output logic                   o_init_busy,
  output logic                   o_pht_we,
  output logic [INDEX_WIDTH-1:0] o_pht_index,
  output logic [1:0]             o_pht_wdata,
  input  logic [1:0]             i_pht_rdata
);

  localparam int DW = $clog2(STARVE_LIMIT + 1);

  PhtState                state_q, state_d;
  logic [INDEX_WIDTH-1:0] init_ptr_q, req_index, fb_index, head_index;
  logic [1:0]             wr_data_q;
  logic [DW-1:0]          defer_cnt_q;
  logic                   drop_q;
  PhtUpdate               head, push_entry;
  logic                   full, empty, one_left;
  logic                   update_req, starve, grant, pop;
  logic                   unused;

  assign req_index  = i_req_pc[INDEX_WIDTH+1:2];
  assign fb_index   = i_fb_pc[INDEX_WIDTH+1:2];
  assign head_index = head.index[INDEX_WIDTH-1:0];
  assign unused     = ^{i_req_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_req_pc[1:0],
                        i_fb_pc[ADDR_WIDTH-1:INDEX_WIDTH+2], i_fb_pc[1:0],
                        head.index[PHT_INDEX_MAX-1:INDEX_WIDTH]};

  always_comb begin
    push_entry                        = '0;
    push_entry.index[INDEX_WIDTH-1:0] = fb_index;
    push_entry.outcome                = i_fb_outcome;
  end

  pht_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (i_fb_valid),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .one_left  (one_left)
  );

  // A pending update wins the port when decode is idle or it has waited too long.
  assign update_req  = (state_q == READ) || (state_q == WRITE);
  assign starve      = (defer_cnt_q == DW'(STARVE_LIMIT));
  assign grant       = update_req && (!i_req_valid || starve);
  assign pop         = grant && (state_q == WRITE);
  assign o_stall_req = update_req && starve;
  assign o_init_busy = (state_q == INIT);
  assign o_fb_drop   = drop_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INIT:  if (init_ptr_q == '1) state_d = IDLE;
      IDLE:  if (i_fb_valid || !empty) state_d = READ;
      READ:  if (grant) state_d = WRITE;
      WRITE: if (grant) state_d = (one_left && !i_fb_valid) ? IDLE : READ;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    o_pht_we         = 1'b0;
    o_pht_index      = req_index;
    o_pht_wdata      = wr_data_q;
    o_req_prediction = i_pht_rdata[1] ? TAKEN : NOT_TAKEN;
    if (state_q == INIT) begin
      o_pht_we         = 1'b1;
      o_pht_index      = init_ptr_q;
      o_pht_wdata      = 2'b10;
      o_req_prediction = TAKEN;
    end else if (grant) begin
      o_pht_we    = (state_q == WRITE);
      o_pht_index = head_index;
    end else if (state_q == WRITE && req_index == head_index) begin
      o_req_prediction = wr_data_q[1] ? TAKEN : NOT_TAKEN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      wr_data_q   <= 2'b10;
      defer_cnt_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= i_fb_valid && full && !pop;
      if (state_q == INIT) init_ptr_q <= init_ptr_q + 1'b1;
      if (grant && state_q == READ) wr_data_q <= sat_update(i_pht_rdata, head.outcome);
      if (grant) defer_cnt_q <= '0;
      else if (update_req && i_req_valid) defer_cnt_q <= defer_cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/pht_port_scheduler.md
# pht_port_scheduler

Shares one single-port pattern history table (PHT) RAM between decode-stage prediction lookups and execute-stage branch feedback updates. Resolved branch outcomes are buffered and applied as read-modify-write of 2-bit saturating counters whenever decode leaves the port free. After every reset the scheduler initialises the whole table. It sits between `branch_controller` (request and feedback side) and the PHT storage.

## Interface
- INDEX_WIDTH, 7: PHT index bits; the table holds 2^INDEX_WIDTH entries.
- FIFO_DEPTH, 4: pending-update buffer depth (power of two, at least 2).
- STARVE_LIMIT, 8: maximum consecutive cycles a pending update may be deferred by lookups.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- i_req_valid  in  1  decode requests a prediction this cycle
- i_req_pc  in  `ADDR_WIDTH  PC of the branch being predicted
- o_req_prediction  out  BranchOutcome  prediction, combinational, same cycle
- o_stall_req  out  1  asks the hazard controller to stall decode this cycle
- i_fb_valid  in  1  execute reports a resolved branch
- i_fb_pc  in  `ADDR_WIDTH  PC of the resolved branch
- i_fb_outcome  in  BranchOutcome  actual outcome
- o_fb_drop  out  1  one-cycle pulse: a feedback update was lost because the buffer was full
- o_init_busy  out  1  table initialisation is in progress
- o_pht_we  out  1  RAM write enable (the port reads when this is low)
- o_pht_index  out  INDEX_WIDTH  RAM address
- o_pht_wdata  out  2  RAM write data
- i_pht_rdata  in  2  RAM read data, combinational from o_pht_index

## Operation
- Index = pc[INDEX_WIDTH+1:2].
- Prediction = TAKEN when the counter's bit 1 is set, otherwise NOT_TAKEN.
- A TAKEN outcome increments the counter, saturating at 2'b11. A NOT_TAKEN outcome decrements it, saturating at 2'b00.
- **INIT state:**
  - Writes 2'b10 to init_ptr and increments init_ptr each cycle.
  - Leaves for IDLE after writing the last entry (init_ptr all-ones).
  - o_req_prediction is forced to TAKEN and lookups do not use the port.
  - Feedback is still pushed into the buffer.
- **IDLE state:** the buffer is empty. A push moves the FSM to READ on the next cycle.
- **READ state:**
  - The port reads the head entry's index and captures the new counter value into wr_data.
  - The FSM then goes to WRITE.
- **WRITE state:**
  - The port writes wr_data to the head index and the head entry is popped.
  - The FSM goes to READ if the buffer is still non-empty, otherwise to IDLE.
- **Port priority outside INIT:**
  - A lookup (i_req_valid) wins the port.
  - A READ or WRITE that loses holds its state, and its wr_data is kept.
  - Each deferral increments defer_cnt.
- **Starvation guard:**
  - When defer_cnt == STARVE_LIMIT, o_stall_req = 1 and the update takes the port that cycle, regardless of i_req_valid.
  - The prediction output is don't-care in that cycle because decode is stalled.
  - defer_cnt clears on every cycle the update takes the port.
- **Bypass:** in WRITE, a lookup whose index equals the held index is predicted from wr_data instead of i_pht_rdata.
- **Buffer full:**
  - A push is accepted if a pop happens in the same cycle.
  - Otherwise the push is dropped and o_fb_drop pulses on the next cycle.
- Two updates to the same index are applied in order. The second READ happens after the first WRITE, so no update is lost.

## Timing
- **Reset values:**
  - state = INIT, init_ptr = 0, buffer empty, defer_cnt = 0.
  - o_fb_drop = 0, o_init_busy = 1, o_stall_req = 0.
  - o_pht_we = 1, o_pht_index = 0, o_pht_wdata = 2'b10, since INIT writes from cycle 0.
- INIT lasts exactly 2^INDEX_WIDTH cycles after reset deasserts.
- o_init_busy falls in the first IDLE cycle.
- **Uncontended update pushed at cycle t:** READ at t+1, WRITE at t+2, the new value is readable at t+3.
- Each deferral cycle adds one cycle to that latency.
- **rst_n asserted mid-operation:** pending updates are discarded and the table is re-initialised.

## Structure
- Add to mips_core_pkg:
  - PhtState enum: INIT, IDLE, READ, WRITE.
  - PhtUpdate struct: index, outcome.
- Sub-module pht_update_fifo:
  - Parameterised circular buffer with push, pop, full, empty and head outputs.
  - Asynchronous reset to empty.

## Test plan
- **Reset with INDEX_WIDTH=3:**
  - 8 writes of 2'b10 to indices 0..7, one per cycle.
  - o_init_busy falls at cycle 8.
  - A lookup during INIT returns TAKEN with o_pht_we = 1.
- **Single NOT_TAKEN feedback for pc 0x14 (index 5):**
  - READ at t+1, write of 2'b01 at t+2.
  - A lookup of 0x14 at t+3 returns NOT_TAKEN.
- **Continuous i_req_valid with STARVE_LIMIT=8 and one pending update:**
  - o_stall_req is high on exactly the 9th cycle.
  - The update proceeds and defer_cnt returns to 0.
- **Bypass:** counter at 2'b10 with NOT_TAKEN feedback held in WRITE by a same-index lookup returns NOT_TAKEN.
- **Overflow with FIFO_DEPTH=4:** 5 feedbacks in 5 cycles with the port blocked.
  - The 5th is dropped and o_fb_drop pulses once.
  - The four accepted updates are applied in order afterwards.
- **Reset mid-update:** rst_n pulses in the WRITE state.
  - No write from the discarded entry occurs.
  - INIT restarts at index 0.
